fp_mul_issue: RTL and testbench

Upstream issue/capture stage wrapped around the combinational FP16 multiplier.
- Buffers operand pairs from a producer in a small FIFO and presents the head pair to the multiplier.
- Registers the multiplier's result and overflow flag into an output register with a valid/ready handshake.
- Keeps a saturating count of overflowing products for the status logic.

---
 rtl/fp_mul_issue.sv | 103 ++++++++++
 tb/tb_fp_mul_issue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_issue.sv
// Issue/capture stage around the combinational FP16 multiplier.
// Operand pairs are buffered in a FIFO. The head pair is issued, and the product is captured into a valid/ready output register.
module fp_mul_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             mul_valid_in,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  input  logic [15:0]      mul_result,
  input  logic             mul_result_vld,
  input  logic             mul_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clear_cnt,
  output logic             proto_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0] mem_a [DEPTH];
  logic [15:0] mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          push;
  logic          issue;

  // A pair can leave only when the output register is free or being drained this cycle.
  always_comb begin
    empty        = (count == '0);
    in_ready     = (count != (AW+1)'(DEPTH));
    push         = in_valid && in_ready;
    issue        = !empty && (!out_valid || out_ready);
    mul_valid_in = issue;
    mul_a        = empty ? 16'h0000 : mem_a[rd_ptr];
    mul_b        = empty ? 16'h0000 : mem_b[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_ovf    <= 1'b0;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_result <= mul_result;
      out_ovf    <= mul_ovf;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // When clear and increment happen in the same cycle, the clear takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count <= '0;
      proto_err <= 1'b0;
    end else begin
      if (clear_cnt)
        ovf_count <= '0;
      else if (issue && mul_ovf && (ovf_count != '1))
        ovf_count <= ovf_count + CNT_W'(1);
      if (issue && !mul_result_vld)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_mul_issue.sv
// Self-checking bench for fp_mul_issue. It uses a stand-in multiplier and a queue-based reference model.
module tb_fp_mul_issue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, mul_valid_in, mul_result_vld, mul_ovf;
  logic out_valid, out_ready, out_ovf, clear_cnt, proto_err;
  logic [15:0] in_a, in_b, mul_a, mul_b, mul_result, out_result;
  logic [CNT_W-1:0] ovf_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] pq[$];
  logic        m_ov;
  logic [15:0] m_res;
  logic        m_ovf;
  int          m_cnt;
  logic        m_perr;
  int          n_push;

  always #5 clk = ~clk;

  fp_mul_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_valid_in(mul_valid_in), .mul_a(mul_a),
    .mul_b(mul_b), .mul_result(mul_result), .mul_result_vld(mul_result_vld),
    .mul_ovf(mul_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .ovf_count(ovf_count),
    .clear_cnt(clear_cnt), .proto_err(proto_err)
  );

  // Stand-in multiplier: the directed FP16 cases are looked up, and other inputs map to an arbitrary tag.
  function automatic logic [16:0] mul_model(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h3C00, 16'h4000}: return {1'b0, 16'h4000};
      {16'h7BFF, 16'h7BFF}: return {1'b1, 16'h7C00};
      {16'h7C00, 16'h0000}: return {1'b1, 16'h7E00};
      {16'h3C00, 16'h3C00}: return {1'b0, 16'h3C00};
      default:              return {a[0] ^ b[15], 16'(a * 16'd3 + b)};
    endcase
  endfunction

  always_comb {mul_ovf, mul_result} = mul_model(mul_a, mul_b);

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    m_ov = 1'b0; m_res = 16'h0000; m_ovf = 1'b0; m_cnt = 0; m_perr = 1'b0;
  endtask

  // One clock cycle: drive the inputs, compare at the falling edge, then advance the model.
  task automatic apply_stimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                input logic rdy, input logic clr, input logic vld);
    logic exp_rdy, exp_issue;
    logic [16:0] r;
    in_valid = v; in_a = a; in_b = b; out_ready = rdy; clear_cnt = clr; mul_result_vld = vld;
    @(negedge clk);
    exp_rdy   = (pq.size() != DEPTH);
    exp_issue = (pq.size() != 0) && (!m_ov || rdy);
    check_output("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_output("mul_valid_in", 32'(mul_valid_in), 32'(exp_issue));
    check_output("mul_ab", {mul_a, mul_b}, (pq.size() != 0) ? pq[0] : 32'h0);
    check_output("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check_output("out_result", 32'(out_result), 32'(m_res));
      check_output("out_ovf", 32'(out_ovf), 32'(m_ovf));
    end
    check_output("ovf_count", 32'(ovf_count), 32'(m_cnt));
    check_output("proto_err", 32'(proto_err), 32'(m_perr));
    if (exp_issue) begin
      r = mul_model(pq[0][31:16], pq[0][15:0]);
      void'(pq.pop_front());
      m_ov = 1'b1; m_res = r[15:0]; m_ovf = r[16];
      if (!vld) m_perr = 1'b1;
      if (clr) m_cnt = 0;
      else if (r[16] && m_cnt < CMAX) m_cnt++;
    end else begin
      if (m_ov && rdy) m_ov = 1'b0;
      if (clr) m_cnt = 0;
    end
    if (v && exp_rdy) begin
      pq.push_back({a, b});
      n_push++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 16'h0, 16'h0, rdy, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    clear_cnt = 1'b0; mul_result_vld = 1'b1; n_push = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_output("rst_out_result", 32'(out_result), 32'h0);
    check_output("rst_out_valid", 32'(out_valid), 32'h0);

    // Single product: latency and result.
    apply_stimulus(1'b1, 16'h3C00, 16'h4000, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    check_output("t1_ovf_count", 32'(ovf_count), 32'd0);

    // Back-to-back overflow cases.
    apply_stimulus(1'b1, 16'h7BFF, 16'h7BFF, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 16'h7C00, 16'h0000, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 16'h3C00, 16'h3C00, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    check_output("t2_ovf_count", 32'(ovf_count), 32'd2);

    // Backpressure: five pairs fit in total (four in the FIFO and one in the output register). Then drain.
    n_push = 0;
    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
    check_output("t3_accepted", 32'(n_push), 32'd5);
    idle(7, 1'b1);

    // Steady state with two entries and simultaneous push and pop.
    apply_stimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);

    // Counter saturation, followed by a clear on the same cycle as an overflowing issue.
    apply_stimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'b1, 16'h7BFF, 16'h7BFF, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    check_output("t5_saturated", 32'(ovf_count), 32'd3);
    apply_stimulus(1'b1, 16'h7BFF, 16'h7BFF, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1);
    check_output("t5_cleared", 32'(ovf_count), 32'd0);
    idle(2, 1'b1);

    // Issue a product while the multiplier reports that its result is not valid.
    apply_stimulus(1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    check_output("proto_err_set", 32'(proto_err), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      apply_stimulus(($urandom % 4) != 0,
                     ($urandom % 8 == 0) ? 16'h7BFF : 16'($urandom),
                     ($urandom % 8 == 0) ? 16'h7BFF : 16'($urandom),
                     ($urandom % 3) != 0, ($urandom % 40) == 0, 1'b1);
    idle(8, 1'b1);

    // Reset mid-operation, with three pairs buffered and the output register full.
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_output("t6_out_valid", 32'(out_valid), 32'd0);
    check_output("t6_in_ready", 32'(in_ready), 32'd1);
    check_output("t6_mul_valid_in", 32'(mul_valid_in), 32'd0);
    check_output("t6_ovf_count", 32'(ovf_count), 32'd0);
    check_output("t6_proto_err", 32'(proto_err), 32'd0);
    apply_stimulus(1'b1, 16'h3C00, 16'h4000, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
